// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and default width for serial_sub
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// rtl/sub_bit_cell.sv - one-bit full subtractor cell, purely combinational
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor, LSB first, one bit per clock
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bor;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bor;
  logic             load;
  logic             last;

  sub_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bor),
    .d    (bit_d),
    .bout (bit_bor)
  );

  assign load = start && ((state == IDLE) || (state == DONE));
  assign last = (state == RUN) && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // On the final bit the operand LSBs hold the original sign bits, so
  // overflow can be judged without keeping extra copies of a and b.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {bit_d, res_sh[WIDTH-1:1]};
      bor    <= bit_bor;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff <= {bit_d, res_sh[WIDTH-1:1]};
        bout <= bit_bor;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (a_sh[0] != b_sh[0]) && (bit_d != a_sh[0]);
`endif
      end
    end
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  minuend; captured on an accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse when diff and bout are valid.
REQ-009 diff  output  WIDTH  registered result a-b, modulo 2^WIDTH.
REQ-010 bout  output  1  registered final borrow; 1 if and only if a<b unsigned.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 IDLE: start=1 SHALL load a and b into shift registers, clear borrow, clear bit counter and go to RUN.
REQ-013 RUN: each cycle SHALL process one bit, LSB first: d=a0^b0^bor; bor_next=(~a0&b0)|(~(a0^b0)&bor).
REQ-014 RUN: d SHALL shift into the result register from the MSB side; operand registers shift right by one; counter increments.
REQ-015 After the WIDTH-th RUN cycle, the FSM SHALL go to DONE, and diff and bout SHALL be updated with the final result.
REQ-016 Latency: start accepted at edge T SHALL give done=1 in the cycle after edge T+WIDTH (WIDTH+1 edges from start to done).
REQ-017 DONE SHALL last exactly one cycle; start=1 in DONE SHALL be accepted as in IDLE (back-to-back), otherwise go to IDLE.
REQ-018 start while in RUN SHALL be ignored; the operation in flight SHALL NOT be disturbed, and a and b SHALL NOT be resampled.
REQ-019 diff and bout SHALL hold their last result until the next DONE, including through IDLE and the next RUN.
REQ-020 a==b SHALL yield diff=0, bout=0; a=0,b=1 SHALL yield diff=all-ones, bout=1.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE and clear busy, done, diff, bout, borrow, counter and shift registers, in any state.
REQ-022 Reset during RUN SHALL abort the operation with no done pulse; start is ignored while rst=1.

Configuration
REQ-023 Macro SERIAL_SUB_OVF_EN defined: an extra output ovf (1 bit) SHALL exist; it is registered and updated with diff.
REQ-024 The ovf output SHALL equal (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]) for the captured operands (two's-complement overflow), and reset to 0.
REQ-025 Macro not defined: the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Shared package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The per-bit datapath SHALL be one sub-module sub_bit_cell (inputs a, b, bin; outputs d, bout), purely combinational, instantiated once.
REQ-028 Counter width SHALL be $clog2(WIDTH+1); no other sub-modules.

Verification
REQ-029 WIDTH=8, a=0x05, b=0x03, start at T -> done high one cycle after edge T+8, diff=0x02, bout=0, ovf=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1 (when enabled).
REQ-031 start pulsed with a=0xFF, b=0x00 on the 3rd RUN cycle of a 0x05-0x03 operation -> result is still 0x02, done pulses only once.
REQ-032 rst asserted on the 4th RUN cycle -> next cycle busy=0, done=0, diff=0x00, bout=0; no done pulse follows.
REQ-033 Back-to-back: start held high through DONE with a=0x10, b=0x20 -> second done 9 cycles after the first, diff=0xF0, bout=1; busy low only during DONE.
REQ-034 Exhaustive WIDTH=4 sweep of all 256 (a,b) pairs -> diff=(a-b) mod 16 and bout=(a<b) for every pair.
